// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: N-master to 1-slave AXI4-Lite read-channel arbiter with round-robin grant.
//
// One transaction is in flight at a time:
//   IDLE -> (grant) -> ADDR -> (m_arready) -> DATA -> (m_rvalid) -> RESP -> (s_rready) -> IDLE
// The response is registered and returned only to the granted master.
//
// Optional feature: define ARB_TIMEOUT_EN to enable a slave-response watchdog. After TIMEOUT
// cycles spent in ADDR/DATA, the arbiter answers the master itself with DECERR and zero data.
// Without the macro, ADDR/DATA wait indefinitely.
//
// Ports:
//   clk, rst              clock (rising edge); asynchronous active-low reset
//   s_araddr/s_arvalid    per-master read address channel in (master i at slice i)
//   s_arready             per-master address accept, one-hot or zero
//   s_rdata/s_rresp       registered response, replicated on every master slice
//   s_rvalid/s_rready     per-master response handshake (s_rvalid one-hot or zero)
//   m_araddr/m_arvalid/m_arready   slave address channel
//   m_rdata/m_rresp/m_rvalid/m_rready  slave read data channel

module axi_rd_arbiter #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_MASTERS*AW-1:0] s_araddr,
    input  logic [N_MASTERS-1:0]    s_arvalid,
    output logic [N_MASTERS-1:0]    s_arready,
    output logic [N_MASTERS*DW-1:0] s_rdata,
    output logic [N_MASTERS*2-1:0]  s_rresp,
    output logic [N_MASTERS-1:0]    s_rvalid,
    input  logic [N_MASTERS-1:0]    s_rready,
    output logic [AW-1:0]           m_araddr,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DW-1:0]           m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready
);

    localparam int unsigned IW = $clog2(N_MASTERS);
    localparam logic [IW-1:0] LastId = IW'(N_MASTERS - 1);

    if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT < 1) begin : g_bad_params
        $error("axi_rd_arbiter: illegal parameter value");
    end

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    state_e        state_q;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] gnt_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] rdata_q;
    logic [1:0]    rresp_q;

    logic          req_any;
    logic [IW-1:0] req_id;
    logic          tmo_hit;

    // Round-robin scan starting at ptr_q; the first requester found wins.
    always_comb begin
        req_any = 1'b0;
        req_id  = ptr_q;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            int unsigned cand;
            cand = (32'(ptr_q) + k) % N_MASTERS;
            if (!req_any && s_arvalid[IW'(cand)]) begin
                req_any = 1'b1;
                req_id  = IW'(cand);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic          busy;
    logic [CW-1:0] cnt_q;

    assign busy    = (state_q == StAddr) || (state_q == StData);
    assign tmo_hit = busy && (cnt_q >= CW'(TIMEOUT - 1));

    // Cleared outside ADDR/DATA, so it restarts from zero on every entry to ADDR.
    // Saturates at the limit so it can never wrap while waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (!busy) begin
            cnt_q <= '0;
        end else if (!tmo_hit) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            rresp_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_any) begin
                        addr_q  <= s_araddr[32'(req_id) * AW +: AW];
                        gnt_q   <= req_id;
                        state_q <= StAddr;
                    end
                end
                StAddr: begin
                    // A real handshake takes priority over the watchdog.
                    if (m_arready) begin
                        state_q <= StData;
                    end else if (tmo_hit) begin
                        rdata_q <= '0;
                        rresp_q <= 2'b11;
                        state_q <= StResp;
                    end
                end
                StData: begin
                    if (m_rvalid) begin
                        rdata_q <= m_rdata;
                        rresp_q <= m_rresp;
                        state_q <= StResp;
                    end else if (tmo_hit) begin
                        rdata_q <= '0;
                        rresp_q <= 2'b11;
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (s_rready[gnt_q]) begin
                        ptr_q   <= (gnt_q == LastId) ? '0 : gnt_q + 1'b1;
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

    // Outputs decode the registered state; s_arready is gated by rst so that nothing is
    // granted while reset is held.
    always_comb begin
        s_arready = '0;
        s_rvalid  = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            s_arready[i] = rst && (state_q == StIdle) && req_any && (req_id == IW'(i));
            s_rvalid[i]  = (state_q == StResp) && (gnt_q == IW'(i));
        end
    end

    assign m_arvalid = (state_q == StAddr);
    assign m_rready  = (state_q == StData);
    assign m_araddr  = addr_q;
    assign s_rdata   = {N_MASTERS{rdata_q}};
    assign s_rresp   = {N_MASTERS{rresp_q}};

endmodule
